// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the parametrised XNOR LFSR and its ranged sampler.
// lfsr_next is the single definition of one generator step, lockup rule included.
package lfsr_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        VALID = 1'b1
    } sampler_state_e;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    // Works on the low 'width' bits; the all-ones state has no XNOR successor, so it falls back to seed.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input logic [31:0] seed,
                                              input int unsigned width);
        logic [31:0] mask;
        logic        fb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb   = ~^(state & taps & mask);
        if ((state & mask) == mask) begin
            return seed & mask;
        end
        return ((state << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Raw XNOR LFSR generator: state register, feedback, run-time seed load and lockup recovery.
// Usable on its own wherever only a pseudo-random word is needed.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step_val;

    assign step_val = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), 32'(SEED), WIDTH));

    // A load wins over a step, so a loaded all-ones seed is only recovered on a later step.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = step_val;
        end
    end

    assign lockup_o = step_i & ~load_i & (&state_q);
    assign state_o  = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/lfsr_sampler.sv
// LFSR generator plus a rejection sampler delivering uniform values in [0, LIMIT)
// over a valid/ready handshake, with sticky lockup and fallback flags.
module lfsr_sampler
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_16),
    parameter logic [WIDTH-1:0] SEED      = '0,
    parameter int unsigned      OUT_W     = 3,
    parameter int unsigned      LIMIT     = 5,
    parameter int unsigned      MAX_TRIES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             flag_clear,
    output logic [WIDTH-1:0] rng_out,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [OUT_W-1:0] sample_data,
    output logic             lockup_flag,
    output logic             reject_ovf
);

    localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);

    sampler_state_e   state_q;
    sampler_state_e   state_d;
    logic [CNT_W-1:0] try_cnt_q;
    logic [CNT_W-1:0] try_cnt_d;
    logic [CNT_W-1:0] try_inc;
    logic [OUT_W-1:0] data_q;
    logic [OUT_W-1:0] data_d;
    logic             lockup_q;
    logic             lockup_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             step;
    logic             core_lockup;
    logic             accept;
    logic             give_up;
    logic             fallback;
    logic [OUT_W-1:0] cand;

    assign step = enable | (state_q == FILL);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .step_i   (step),
        .load_i   (seed_load),
        .seed_i   (seed_in),
        .state_o  (rng_out),
        .lockup_o (core_lockup)
    );

    // The candidate always comes from the pre-step state, even in a seed-load cycle.
    assign cand = rng_out[OUT_W-1:0];

    generate
        if (64'(LIMIT) >= (64'd1 << OUT_W)) begin : g_full_range
            assign accept = 1'b1;
        end else begin : g_compare
            assign accept = ({1'b0, cand} < (OUT_W + 1)'(LIMIT));
        end
    endgenerate

    assign try_inc  = try_cnt_q + 1'b1;
    assign give_up  = (try_inc == CNT_W'(MAX_TRIES));
    assign fallback = (state_q == FILL) & ~accept & ~seed_load & give_up;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept || fallback) state_d = VALID;
            VALID:   if (sample_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        sample_valid = (state_q == VALID);
        sample_data  = data_q;
        lockup_flag  = lockup_q;
        reject_ovf   = ovf_q;
    end

    // A seed load restarts the rejection budget, so it also suppresses the fallback that cycle.
    always_comb begin
        try_cnt_d = try_cnt_q;
        data_d    = data_q;
        if (state_q == FILL) begin
            if (accept) begin
                data_d    = cand;
                try_cnt_d = '0;
            end else if (seed_load) begin
                try_cnt_d = '0;
            end else if (fallback) begin
                data_d    = '0;
                try_cnt_d = '0;
            end else begin
                try_cnt_d = try_inc;
            end
        end
    end

    assign lockup_d = core_lockup | (lockup_q & ~flag_clear);
    assign ovf_d    = fallback | (ovf_q & ~flag_clear);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            try_cnt_q <= '0;
            data_q    <= '0;
            lockup_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            try_cnt_q <= try_cnt_d;
            data_q    <= data_d;
            lockup_q  <= lockup_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_lfsr_sampler.sv
// Scoreboard bench for lfsr_sampler: two 8-bit instances (MAX_TRIES 8 and 3) share stimulus,
// expected samples are queued by the stimulus process and popped by a handshake monitor.
module tb_lfsr_sampler;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       seedLoad;
    logic [7:0] seedIn;
    logic       flagClear;
    logic       sampleReady;

    logic [7:0] rngA,   rngB;
    logic       validA, validB;
    logic [2:0] dataA,  dataB;
    logic       lockA,  lockB;
    logic       ovfA,   ovfB;

    int compared   = 0;
    int mismatched = 0;
    int cycleCnt   = 0;

    logic [7:0] expA[$];
    logic [7:0] expB[$];
    int         popCycA[$];
    int         popCycB[$];

    always #5 clock = ~clock;
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    lfsr_sampler #(
        .WIDTH(8), .TAPS(8'hB8), .SEED(8'h00), .OUT_W(3), .LIMIT(5), .MAX_TRIES(8)
    ) dutA (
        .clock(clock), .reset(reset), .enable(enable), .seed_load(seedLoad),
        .seed_in(seedIn), .flag_clear(flagClear), .rng_out(rngA),
        .sample_valid(validA), .sample_ready(sampleReady), .sample_data(dataA),
        .lockup_flag(lockA), .reject_ovf(ovfA)
    );

    lfsr_sampler #(
        .WIDTH(8), .TAPS(8'hB8), .SEED(8'h00), .OUT_W(3), .LIMIT(5), .MAX_TRIES(3)
    ) dutB (
        .clock(clock), .reset(reset), .enable(enable), .seed_load(seedLoad),
        .seed_in(seedIn), .flag_clear(flagClear), .rng_out(rngB),
        .sample_valid(validB), .sample_ready(sampleReady), .sample_data(dataB),
        .lockup_flag(lockB), .reject_ovf(ovfB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one set of inputs across exactly one rising edge, returning 1 time unit after it.
    task automatic applyStimulus(input logic en, input logic ld, input logic [7:0] sd, input logic clr);
        enable    = en;
        seedLoad  = ld;
        seedIn    = sd;
        flagClear = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic waitPops(input int targetA, input int targetB);
        int n;
        n = 0;
        while ((popCycA.size() < targetA || popCycB.size() < targetB) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("popsA", popCycA.size(), targetA);
        checkOutput("popsB", popCycB.size(), targetB);
    endtask

    function automatic logic [7:0] modelStep(input logic [7:0] s);
        if (s == 8'hFF) return 8'h00;
        return {s[6:0], ~^(s & 8'hB8)};
    endfunction

    always @(negedge clock) begin
        if (!reset && sampleReady) begin
            if (validA) begin
                if (expA.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL sampleA unexpected: got %0d, none queued", dataA);
                end else begin
                    checkOutput("sampleA", 32'(dataA), 32'(expA.pop_front()));
                end
                popCycA.push_back(cycleCnt);
            end
            if (validB) begin
                if (expB.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL sampleB unexpected: got %0d, none queued", dataB);
                end else begin
                    checkOutput("sampleB", 32'(dataB), 32'(expB.pop_front()));
                end
                popCycB.push_back(cycleCnt);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] seq   [7] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        logic       enPat [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       ldPat [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] sdPat [10] = '{8'h00, 8'h00, 8'hA5, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h81};
        logic       seen  [256];
        logic [7:0] model;
        int         steps;
        int         repeats;
        int         baseA;
        int         baseB;

        reset = 1'b1; enable = 1'b0; seedLoad = 1'b0; seedIn = 8'h00;
        flagClear = 1'b0; sampleReady = 1'b0;
        #2;
        checkOutput("rst rngA", 32'(rngA), 32'h00);
        checkOutput("rst validA", 32'(validA), 0);
        checkOutput("rst dataA", 32'(dataA), 0);
        checkOutput("rst lockA", 32'(lockA), 0);
        checkOutput("rst ovfB", 32'(ovfB), 0);

        // Free-running sequence and full period.
        enable = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        checkOutput("seq0", 32'(rngA), 32'(seq[0]));
        seen[rngA] = 1'b1;
        for (int i = 1; i < 7; i++) begin
            @(posedge clock); #1;
            checkOutput($sformatf("seq%0d", i), 32'(rngA), 32'(seq[i]));
            seen[rngA] = 1'b1;
        end
        steps   = 6;
        repeats = 0;
        while (rngA != 8'h00 && steps < 300) begin
            @(posedge clock); #1;
            steps++;
            if (rngA != 8'h00 && seen[rngA]) repeats++;
            seen[rngA] = 1'b1;
        end
        checkOutput("period", steps, 255);
        checkOutput("repeats", repeats, 0);

        // All-ones seed recovery and sticky flag behaviour.
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        checkOutput("load FF", 32'(rngA), 32'hFF);
        checkOutput("lock before step", 32'(lockA), 0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("lockup rng", 32'(rngA), 32'h00);
        checkOutput("lockup flag", 32'(lockA), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("lock cleared", 32'(lockA), 0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("set beats clear", 32'(lockA), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Ranged sample stream from reset: rejections, latency and fallback.
        reset = 1'b1;
        sampleReady = 1'b1;
        @(posedge clock); #1;
        baseA = popCycA.size();
        baseB = popCycB.size();
        expA.push_back(8'd0); expA.push_back(8'd1); expA.push_back(8'd3); expA.push_back(8'd2); expA.push_back(8'd4);
        expB.push_back(8'd0); expB.push_back(8'd1); expB.push_back(8'd3); expB.push_back(8'd0); expB.push_back(8'd2);
        reset = 1'b0;
        waitPops(baseA + 5, baseB + 5);
        sampleReady = 1'b0;
        checkOutput("gap first", popCycA[baseA + 1] - popCycA[baseA], 2);
        checkOutput("gap after rejects", popCycA[baseA + 3] - popCycA[baseA + 2], 6);
        checkOutput("ovfA", 32'(ovfA), 0);
        checkOutput("ovfB", 32'(ovfB), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("ovfB cleared", 32'(ovfB), 0);
        flagClear = 1'b0;

        // Asynchronous reset while both instances hold a valid sample.
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midVALID validA", 32'(validA), 0);
        checkOutput("midVALID dataB", 32'(dataB), 0);
        checkOutput("midVALID rngA", 32'(rngA), 32'h00);

        // Held sample stays stable while the generator is driven around it.
        @(posedge clock); #1;
        sampleReady = 1'b1;
        expA.push_back(8'd0);
        expB.push_back(8'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        sampleReady = 1'b0;
        @(posedge clock); #1;
        model = 8'h03;
        checkOutput("hold start rng", 32'(rngA), 32'(model));
        checkOutput("hold start data", 32'(dataA), 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(enPat[i], ldPat[i], sdPat[i], 1'b0);
            if (ldPat[i]) model = sdPat[i];
            else if (enPat[i]) model = modelStep(model);
            checkOutput($sformatf("hold rng%0d", i), 32'(rngA), 32'(model));
            checkOutput($sformatf("hold valid%0d", i), 32'(validA), 1);
            checkOutput($sformatf("hold dataA%0d", i), 32'(dataA), 1);
            checkOutput($sformatf("hold dataB%0d", i), 32'(dataB), 1);
        end
        checkOutput("hold lockup", 32'(lockA), 1);

        // Asynchronous reset in the middle of a rejection run, then a fresh first sample.
        enable = 1'b0; seedLoad = 1'b0; seedIn = 8'h00;
        reset = 1'b1;
        @(posedge clock); #1;
        baseA = popCycA.size();
        expA.push_back(8'd0); expA.push_back(8'd1); expA.push_back(8'd3);
        expB.push_back(8'd0); expB.push_back(8'd1); expB.push_back(8'd3);
        sampleReady = 1'b1;
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midFILL pops", popCycA.size(), baseA + 3);
        checkOutput("midFILL rngA", 32'(rngA), 32'h00);
        checkOutput("midFILL dataA", 32'(dataA), 0);
        checkOutput("midFILL validB", 32'(validB), 0);
        @(posedge clock); #1;
        expA.push_back(8'd0);
        expB.push_back(8'd0);
        reset = 1'b0;
        waitPops(popCycA.size() + 1, popCycB.size() + 1);
        sampleReady = 1'b0;

        checkOutput("expA drained", expA.size(), 0);
        checkOutput("expB drained", expB.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
